// File: rtl/lab1_led_logic.sv
// Board demo: two synchronized keys drive six logic-function LEDs and a
// 4-bit count of key[1] presses. Every LED bit comes straight from a flop.
module lab1_led_logic #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key,
  output logic [9:0] led
);

  localparam int unsigned KEY_W = 2;
  localparam int unsigned LOG_W = 6;
  localparam int unsigned CNT_W = 4;

  logic [KEY_W-1:0] sync_q [SYNC_STAGES];
  logic [KEY_W-1:0] ks;
  logic             ks1_d;
  logic             rise_c;
  logic [LOG_W-1:0] logic_c;

  assign ks     = sync_q[SYNC_STAGES-1];
  assign rise_c = ks[1] & ~ks1_d;

  // Basic gate functions of the synchronized keys, MSB first: NOR NAND XOR NOT OR AND
  always_comb begin
    logic_c = '0;
    logic_c = {~(ks[0] | ks[1]),
               ~(ks[0] & ks[1]),
               ks[0] ^ ks[1],
               ~ks[0],
               ks[0] | ks[1],
               ks[0] & ks[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      ks1_d <= 1'b0;
      led   <= '0;
    end else begin
      sync_q[0] <= key;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      ks1_d              <= ks[1];
      led[LOG_W-1:0]     <= logic_c;
      // Count lands on the same edge as the logic update for the same ks sample
      if (rise_c) begin
        led[9:LOG_W] <= led[9:LOG_W] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lab1_led_logic.sv
// Directed bench for lab1_led_logic: reset, truth table, latency, counter
// wrap, mid-run reset and key held through reset.
module tb_lab1_led_logic;

  logic       clk;
  logic       rst_n;
  logic [1:0] key;
  logic [9:0] led;

  int n_total;
  int n_bad;

  lab1_led_logic #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key   = 2'b00;
    ticks(2);
    rst_n = 1'b1;
    ticks(4);
  endtask

  localparam logic [5:0] P00 = 6'b110100;
  localparam logic [5:0] P01 = 6'b011010;
  localparam logic [5:0] P10 = 6'b011110;
  localparam logic [5:0] P11 = 6'b000011;

  logic [1:0] keys [4];
  logic [5:0] pats [4];
  logic [3:0] cnts [4];

  initial begin
    n_total = 0;
    n_bad   = 0;
    keys[0] = 2'b00; pats[0] = P00; cnts[0] = 4'd0;
    keys[1] = 2'b01; pats[1] = P01; cnts[1] = 4'd0;
    keys[2] = 2'b10; pats[2] = P10; cnts[2] = 4'd1;
    keys[3] = 2'b11; pats[3] = P11; cnts[3] = 4'd1;

    // Reset held with both keys pressed
    rst_n = 1'b0;
    key   = 2'b11;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", led, 10'b0);
    end
    rst_n = 1'b1;
    key   = 2'b00;
    tick();
    chk("reset_release", led, {4'd0, P00});

    // Truth table with 3-edge latency check on each change
    begin
      logic [5:0] prev_p;
      logic [3:0] prev_c;
      prev_p = P00;
      prev_c = 4'd0;
      for (int s = 0; s < 4; s++) begin
        key = keys[s];
        tick();
        chk("tt_edge1", led, {prev_c, prev_p});
        tick();
        chk("tt_edge2", led, {prev_c, prev_p});
        tick();
        chk("tt_edge3", led, {cnts[s], pats[s]});
        ticks(7);
        chk("tt_hold", led, {cnts[s], pats[s]});
        prev_p = pats[s];
        prev_c = cnts[s];
      end
    end

    // Latency for a 00 -> 11 step
    do_reset();
    chk("lat_base", led, {4'd0, P00});
    key = 2'b11;
    tick();
    chk("lat_edge1", led, {4'd0, P00});
    tick();
    chk("lat_edge2", led, {4'd0, P00});
    tick();
    chk("lat_edge3", led, {4'd1, P11});

    // Counter wrap over 17 key[1] pulses
    do_reset();
    for (int p = 1; p <= 17; p++) begin
      key = 2'b10;
      ticks(4);
      key = 2'b00;
      ticks(4);
      chk("wrap_cnt", {6'd0, led[9:6]}, {6'd0, 4'(p % 16)});
    end
    chk("wrap_logic", led, {4'd1, P00});
    for (int t = 0; t < 4; t++) begin
      key = (t % 2 == 0) ? 2'b01 : 2'b00;
      ticks(4);
      chk("key0_no_count", {6'd0, led[9:6]}, 10'd1);
    end

    // Reset in the middle of a count
    do_reset();
    for (int p = 0; p < 5; p++) begin
      key = 2'b10;
      ticks(4);
      key = 2'b00;
      ticks(4);
    end
    chk("mid_cnt5", led, {4'd5, P00});
    rst_n = 1'b0;
    tick();
    chk("mid_reset", led, 10'b0);
    rst_n = 1'b1;
    tick();
    chk("mid_release", led, {4'd0, P00});
    ticks(5);
    chk("mid_restart", led, {4'd0, P00});

    // key[1] held high through reset release counts once
    rst_n = 1'b0;
    key   = 2'b10;
    ticks(2);
    chk("held_reset", led, 10'b0);
    rst_n = 1'b1;
    tick();
    chk("held_edge1", led, {4'd0, P00});
    tick();
    chk("held_edge2", led, {4'd0, P00});
    tick();
    chk("held_edge3", led, {4'd1, P10});
    ticks(10);
    chk("held_steady", led, {4'd1, P10});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
